// File: rtl/mux8to1_rr_stream.sv
// rtl/mux8to1_rr_stream.sv - registered 8:1 valid/ready collector with round-robin arbitration
// Optional build macro: MUX_FIXED_PRI_EN (lowest-index valid channel always wins, no rr_ptr)
module mux8to1_rr_stream #(
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          in_valid,
  input  logic [8*DATA_W-1:0] in_data,
  output logic [7:0]          in_ready,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  output logic [2:0]          out_sel,
  input  logic                out_ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t              state_q;
  state_t              state_d;
  logic                load_ok;
  logic                gnt_found;
  logic [2:0]          gnt_idx;
  logic [2:0]          search_base;
  logic                xfer;
  logic [DATA_W-1:0]   gnt_word;

`ifdef MUX_FIXED_PRI_EN
  assign search_base = 3'd0;
`else
  logic [2:0] rr_ptr;

  // Pointer moves one past the channel that just transferred; idle cycles leave it alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 3'd0;
    end else if (xfer) begin
      rr_ptr <= gnt_idx + 3'd1;
    end
  end

  assign search_base = rr_ptr;
`endif

  // Search valid bits ascending from search_base, wrapping 7->0; first hit wins
  always_comb begin
    logic [2:0] cand;
    gnt_found = 1'b0;
    gnt_idx   = 3'd0;
    cand      = 3'd0;
    for (int k = 0; k < 8; k++) begin
      cand = search_base + 3'(k);
      if (!gnt_found && in_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // Pick only the granted channel's word so unknowns on other channels stay out of the register
  always_comb begin
    gnt_word = '0;
    for (int k = 0; k < 8; k++) begin
      if (gnt_idx == 3'(k)) begin
        gnt_word = in_data[k*DATA_W +: DATA_W];
      end
    end
  end

  assign xfer = gnt_found & load_ok & rst_n;

  // Output-register occupancy: EMPTY/FULL
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Fill on any grant; drain when the consumer takes the word and nothing replaces it
  always_comb begin
    state_d = state_q;
    if (xfer) begin
      state_d = FULL;
    end else if (state_q == FULL && out_ready) begin
      state_d = EMPTY;
    end
  end

  // Ready goes only to the granted channel, and only when the register can accept a word
  always_comb begin
    out_valid = (state_q == FULL);
    load_ok   = (state_q == EMPTY) | out_ready;
    in_ready  = 8'd0;
    if (rst_n && gnt_found && load_ok) begin
      in_ready[gnt_idx] = 1'b1;
    end
  end

  // Capture word and source index on the handshake edge; hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_sel  <= 3'd0;
    end else if (xfer) begin
      out_data <= gnt_word;
      out_sel  <= gnt_idx;
    end
  end

endmodule
